// File: rtl/a2_timer_seq.sv
// rtl/a2_timer_seq.sv - start/stop sequencer driving the a2_timer control inputs
// Optional T12 watchdog with alarm restart: define TIMER_WDOG_EN.
module a2_timer_seq #(
  parameter int STRT_MCT = 4,
  parameter int GOJ_CYC  = 8
`ifdef TIMER_WDOG_EN
  ,
  parameter int WDOG_CYC = 64
`endif
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST_,
  input  logic       T12,
  input  logic       REQ_RESTART,
  input  logic       REQ_HALT,
  input  logic       REQ_STEP,
  input  logic       REQ_RUN,
  input  logic       REQ_STBY,
  input  logic       REQ_WAKE,
  output logic       STRT1,
  output logic       STRT2,
  output logic       GOJ1,
  output logic       MSTP,
  output logic       MSTRTP,
  output logic       SBY,
  output logic       ALGA,
  output logic [2:0] STATE,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_POR    = 3'd0,
    S_STRT   = 3'd1,
    S_GOJ    = 3'd2,
    S_RUN    = 3'd3,
    S_HALT   = 3'd4,
    S_STEP   = 3'd5,
    S_SBYREQ = 3'd6,
    S_SBY    = 3'd7
  } state_t;

  // Last STRT edge index (edge counter never exceeds it) and GOJ reload value.
  localparam logic [7:0] STRT_LAST = 8'(STRT_MCT - 1);
  localparam logic [7:0] GOJ_LOAD  = 8'(GOJ_CYC);

  state_t     state;
  state_t     state_nxt;
  logic       t12_q;
  logic       t12e;
  logic       restart_ok;
  logic [7:0] strt_cnt;
  logic [7:0] strt_nxt;
  logic [7:0] goj_cnt;
  logic [7:0] goj_nxt;

`ifdef TIMER_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYC - 1);
  logic [15:0] wdog_cnt;
  logic [15:0] wdog_nxt;
  logic        wdog_fire;
  logic        alga_q;
  logic        alga_nxt;
`endif

  // One pulse per MCT: rising edge of the sampled T12 level.
  assign t12e = T12 & ~t12_q;

  // Restart is refused only while the power-up sequence itself is running.
  assign restart_ok = REQ_RESTART && (state != S_POR) && (state != S_STRT);

  assign STATE = state;

  // Next-state and counter update; requests outrank T12 edges in the same cycle.
  always_comb begin
    state_nxt = state;
    strt_nxt  = strt_cnt;
    goj_nxt   = goj_cnt;
`ifdef TIMER_WDOG_EN
    wdog_nxt  = wdog_cnt;
    wdog_fire = 1'b0;
    alga_nxt  = 1'b0;
`endif
    case (state)
      S_POR: state_nxt = S_STRT;
      S_STRT: begin
        if (t12e) begin
          if (strt_cnt == STRT_LAST) state_nxt = S_GOJ;
          else                       strt_nxt  = strt_cnt + 8'd1;
        end
      end
      S_GOJ: begin
        if (!restart_ok) begin
          if (goj_cnt <= 8'd1) state_nxt = S_RUN;
          else                 goj_nxt   = goj_cnt - 8'd1;
        end
      end
      S_RUN: begin
        if (restart_ok)    state_nxt = S_GOJ;
        else if (REQ_STBY) state_nxt = S_SBYREQ;
        else if (REQ_HALT) state_nxt = S_HALT;
        else begin
`ifdef TIMER_WDOG_EN
          if (t12e) begin
            wdog_nxt = 16'd0;
          end else if (wdog_cnt == WDOG_LAST) begin
            state_nxt = S_GOJ;
            wdog_fire = 1'b1;
          end else begin
            wdog_nxt = wdog_cnt + 16'd1;
          end
`endif
        end
      end
      S_HALT: begin
        if (restart_ok)    state_nxt = S_GOJ;
        else if (REQ_STBY) state_nxt = S_SBYREQ;
        else if (REQ_STEP) state_nxt = S_STEP;
        else if (REQ_RUN)  state_nxt = S_RUN;
      end
      S_STEP: begin
        if (restart_ok) state_nxt = S_GOJ;
        else if (t12e)  state_nxt = S_HALT;
      end
      S_SBYREQ: begin
        if (restart_ok) state_nxt = S_GOJ;
        else if (t12e)  state_nxt = S_SBY;
      end
      S_SBY: begin
        if (restart_ok || REQ_WAKE) state_nxt = S_GOJ;
      end
    endcase

    // Per-state counters start fresh on every transition.
    if (state_nxt != state) begin
      strt_nxt = 8'd0;
`ifdef TIMER_WDOG_EN
      wdog_nxt = 16'd0;
`endif
    end
    // Any entry into GOJ, or a restart while already there, reloads the period.
    if ((state_nxt == S_GOJ) && ((state != S_GOJ) || restart_ok)) goj_nxt = GOJ_LOAD;
`ifdef TIMER_WDOG_EN
    // Alarm covers the whole GOJ period that the watchdog started.
    alga_nxt = (state_nxt == S_GOJ) && (wdog_fire || (alga_q && !restart_ok));
`endif
  end

  // State register, T12 history and sequencing counters.
  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST_) begin
      state    <= S_POR;
      t12_q    <= 1'b0;
      strt_cnt <= 8'd0;
      goj_cnt  <= 8'd0;
    end else begin
      state    <= state_nxt;
      t12_q    <= T12;
      strt_cnt <= strt_nxt;
      goj_cnt  <= goj_nxt;
    end
  end

`ifdef TIMER_WDOG_EN
  // Watchdog quiet-cycle counter and alarm flag.
  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST_) begin
      wdog_cnt <= 16'd0;
      alga_q   <= 1'b0;
    end else begin
      wdog_cnt <= wdog_nxt;
      alga_q   <= alga_nxt;
    end
  end

  assign ALGA = alga_q;
`else
  assign ALGA = 1'b0;
`endif

  // Moore output decode of the next state, registered so it lines up with STATE.
  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST_) begin
      STRT1  <= 1'b0;
      STRT2  <= 1'b0;
      GOJ1   <= 1'b0;
      MSTP   <= 1'b0;
      MSTRTP <= 1'b0;
      SBY    <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      STRT1  <= (state_nxt == S_STRT);
      STRT2  <= (state_nxt == S_STRT);
      GOJ1   <= (state_nxt == S_GOJ);
      MSTP   <= (state_nxt == S_HALT) || (state_nxt == S_STEP);
      MSTRTP <= (state_nxt == S_STEP);
      SBY    <= (state_nxt == S_SBY);
      BUSY   <= (state_nxt == S_STRT) || (state_nxt == S_GOJ) ||
                (state_nxt == S_STEP) || (state_nxt == S_SBYREQ);
    end
  end

endmodule

// File: tb/tb_a2_timer_seq.sv
// tb/tb_a2_timer_seq.sv - self-checking bench for a2_timer_seq with a cycle reference model
module tb_a2_timer_seq;

  localparam int STRT_MCT = 4;
  localparam int GOJ_CYC  = 8;
  localparam int T_PER    = 20;
`ifdef TIMER_WDOG_EN
  localparam int WDOG_CYC = 64;
`endif

  logic       SIM_CLK = 1'b0;
  logic       SIM_RST_ = 1'b0;
  logic       T12 = 1'b0;
  logic       REQ_RESTART = 1'b0;
  logic       REQ_HALT = 1'b0;
  logic       REQ_STEP = 1'b0;
  logic       REQ_RUN = 1'b0;
  logic       REQ_STBY = 1'b0;
  logic       REQ_WAKE = 1'b0;
  logic       STRT1, STRT2, GOJ1, MSTP, MSTRTP, SBY, ALGA, BUSY;
  logic [2:0] STATE;

  int n_checks = 0;
  int n_fail   = 0;

  int phase  = 0;
  int period = T_PER;
  bit t12_run = 1'b0;

  // Reference model: spec-level state number plus remaining-work counters.
  int m_state    = 0;
  int m_edges    = 0;
  int m_goj_left = 0;
  bit m_alga     = 1'b0;
  bit m_prev     = 1'b0;
`ifdef TIMER_WDOG_EN
  int m_quiet    = 0;
`endif

  a2_timer_seq dut (
    .SIM_CLK(SIM_CLK), .SIM_RST_(SIM_RST_), .T12(T12),
    .REQ_RESTART(REQ_RESTART), .REQ_HALT(REQ_HALT), .REQ_STEP(REQ_STEP),
    .REQ_RUN(REQ_RUN), .REQ_STBY(REQ_STBY), .REQ_WAKE(REQ_WAKE),
    .STRT1(STRT1), .STRT2(STRT2), .GOJ1(GOJ1), .MSTP(MSTP), .MSTRTP(MSTRTP),
    .SBY(SBY), .ALGA(ALGA), .STATE(STATE), .BUSY(BUSY)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  // Request index: 0 restart, 1 stby, 2 halt, 3 step, 4 run, 5 wake (priority order).
  function automatic bit legal(int r, int st);
    case (r)
      0:       return st >= 2;
      1:       return st == 3 || st == 4;
      2:       return st == 3;
      3:       return st == 4;
      4:       return st == 4;
      default: return st == 7;
    endcase
  endfunction

  function automatic int target(int r);
    int tgt [6] = '{2, 6, 4, 5, 3, 2};
    return tgt[r];
  endfunction

  function automatic logic [10:0] dut_vec();
    return {STATE, STRT1, STRT2, GOJ1, MSTP, MSTRTP, SBY, ALGA, BUSY};
  endfunction

  // Bits: STRT1 STRT2 GOJ1 MSTP MSTRTP SBY ALGA BUSY
  function automatic logic [10:0] mdl_vec();
    logic [7:0] o;
    case (m_state)
      1:       o = 8'b1100_0001;
      2:       o = m_alga ? 8'b0010_0011 : 8'b0010_0001;
      4:       o = 8'b0001_0000;
      5:       o = 8'b0001_1001;
      6:       o = 8'b0000_0001;
      7:       o = 8'b0000_0100;
      default: o = 8'b0000_0000;
    endcase
    return {3'(m_state), o};
  endfunction

  task automatic model_clock();
    bit edge_seen;
    int win;
    int nxt;
    logic [5:0] rq;
    edge_seen = T12 && !m_prev;
    if (!SIM_RST_) begin
      m_state = 0; m_edges = 0; m_goj_left = 0; m_alga = 1'b0; m_prev = 1'b0;
`ifdef TIMER_WDOG_EN
      m_quiet = 0;
`endif
      return;
    end
    m_prev = T12;
    rq = {REQ_WAKE, REQ_RUN, REQ_STEP, REQ_HALT, REQ_STBY, REQ_RESTART};
    win = -1;
    for (int r = 0; r < 6; r++)
      if (win < 0 && rq[r] && legal(r, m_state)) win = r;
    nxt = m_state;
    if (win >= 0) begin
      nxt = target(win);
      if (nxt == 2) begin m_goj_left = GOJ_CYC; m_alga = 1'b0; end
    end else begin
      case (m_state)
        0: nxt = 1;
        1: if (edge_seen) begin
             if (m_edges < STRT_MCT) m_edges++;
             if (m_edges == STRT_MCT) begin nxt = 2; m_goj_left = GOJ_CYC; end
           end
        2: begin m_goj_left--; if (m_goj_left == 0) nxt = 3; end
        3: begin
`ifdef TIMER_WDOG_EN
             if (edge_seen) m_quiet = 0;
             else if (m_quiet == WDOG_CYC - 1) begin
               nxt = 2; m_goj_left = GOJ_CYC; m_alga = 1'b1;
             end else m_quiet++;
`endif
           end
        5: if (edge_seen) nxt = 4;
        6: if (edge_seen) nxt = 7;
        default: ;
      endcase
    end
    if (nxt != m_state) begin
      m_edges = 0;
`ifdef TIMER_WDOG_EN
      m_quiet = 0;
`endif
      if (nxt != 2) m_alga = 1'b0;
    end
    m_state = nxt;
  endtask

  // Advance one clock: drive T12, step the model, sample 1 time unit after the edge.
  task automatic tick();
    if (t12_run) T12 = (phase % period) < (period / 2);
    model_clock();
    @(posedge SIM_CLK);
    #1;
    phase++;
    REQ_RESTART = 1'b0; REQ_HALT = 1'b0; REQ_STEP = 1'b0;
    REQ_RUN = 1'b0; REQ_STBY = 1'b0; REQ_WAKE = 1'b0;
  endtask

  task automatic test_reset();
    SIM_RST_ = 1'b0; t12_run = 1'b0; T12 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dut_vec() !== 11'd0) begin
        n_fail++; $display("FAIL reset_state got %b want %b", dut_vec(), 11'd0);
      end
    end
  endtask

  task automatic test_power_up();
    int strt_cyc;
    int goj_cyc;
    int n;
    strt_cyc = 0; goj_cyc = 0; n = 0;
    SIM_RST_ = 1'b1; t12_run = 1'b1; period = T_PER; phase = T_PER / 2;
    while (STATE !== 3'd3 && n < 400) begin
      tick(); n++;
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL power_up_seq got %b want %b", dut_vec(), mdl_vec());
      end
      if (STRT1 && STRT2) strt_cyc++;
      if (GOJ1) goj_cyc++;
    end
    n_checks++;
    if (STATE !== 3'd3) begin n_fail++; $display("FAIL power_up_run got %0d want 3", STATE); end
    n_checks++;
    if (strt_cyc != T_PER / 2 + (STRT_MCT - 1) * T_PER) begin
      n_fail++; $display("FAIL power_up_strt_len got %0d want %0d", strt_cyc, T_PER / 2 + (STRT_MCT - 1) * T_PER);
    end
    n_checks++;
    if (goj_cyc != GOJ_CYC) begin n_fail++; $display("FAIL power_up_goj_len got %0d want %0d", goj_cyc, GOJ_CYC); end
  endtask

  task automatic test_halt_step();
    int n;
    REQ_HALT = 1'b1; tick();
    n_checks++;
    if ({STATE, MSTP, BUSY} !== {3'd4, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL halt_enter got %b want %b", {STATE, MSTP, BUSY}, {3'd4, 1'b1, 1'b0});
    end
    REQ_STEP = 1'b1; tick();
    n_checks++;
    if ({STATE, MSTP, MSTRTP} !== {3'd5, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL step_enter got %b want %b", {STATE, MSTP, MSTRTP}, {3'd5, 1'b1, 1'b1});
    end
    n = 0;
    while (STATE === 3'd5 && n < 100) begin
      tick(); n++;
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL step_seq got %b want %b", dut_vec(), mdl_vec());
      end
    end
    n_checks++;
    if ({STATE, MSTP, MSTRTP} !== {3'd4, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL step_done got %b want %b", {STATE, MSTP, MSTRTP}, {3'd4, 1'b1, 1'b0});
    end
    REQ_RUN = 1'b1; tick();
    n_checks++;
    if (dut_vec() !== {3'd3, 8'd0}) begin n_fail++; $display("FAIL halt_exit got %b want %b", dut_vec(), {3'd3, 8'd0}); end
  endtask

  task automatic test_standby();
    int n;
    int n6;
    int g;
    n = 0;
    while ((phase % T_PER) != T_PER - 5 && n < 100) begin tick(); n++; end
    REQ_STBY = 1'b1; tick();
    n6 = 0; n = 0;
    while (STATE === 3'd6 && n < 50) begin
      n6++; tick(); n++;
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL stby_seq got %b want %b", dut_vec(), mdl_vec());
      end
    end
    n_checks++;
    if (n6 != 5) begin n_fail++; $display("FAIL stby_wait_len got %0d want 5", n6); end
    n_checks++;
    if ({STATE, SBY} !== {3'd7, 1'b1}) begin n_fail++; $display("FAIL stby_enter got %b want %b", {STATE, SBY}, {3'd7, 1'b1}); end
    REQ_WAKE = 1'b1; tick();
    n_checks++;
    if ({STATE, SBY, GOJ1} !== {3'd2, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL wake_goj got %b want %b", {STATE, SBY, GOJ1}, {3'd2, 1'b0, 1'b1});
    end
    g = 1; n = 0;
    while (STATE === 3'd2 && n < 50) begin tick(); n++; if (GOJ1) g++; end
    n_checks++;
    if ({g, STATE} !== {GOJ_CYC, 3'd3}) begin n_fail++; $display("FAIL wake_goj_len got %0d/%0d want %0d/3", g, STATE, GOJ_CYC); end
  endtask

  task automatic test_priority();
    int n;
    REQ_RESTART = 1'b1; REQ_STBY = 1'b1; tick();
    n_checks++;
    if ({STATE, SBY, GOJ1} !== {3'd2, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL prio_restart got %b want %b", {STATE, SBY, GOJ1}, {3'd2, 1'b0, 1'b1});
    end
    n = 0;
    while (STATE === 3'd2 && n < 50) begin
      tick(); n++;
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL prio_goj got %b want %b", dut_vec(), mdl_vec()); end
    end
    REQ_RUN = 1'b1; tick();
    n_checks++;
    if (dut_vec() !== {3'd3, 8'd0}) begin n_fail++; $display("FAIL prio_run_in_run got %b want %b", dut_vec(), {3'd3, 8'd0}); end
  endtask

  task automatic test_back_to_back();
    int g;
    int n;
    g = 0;
    for (int k = 0; k <= 10; k++) begin
      if (k == 0 || k == 5 || k == 10) REQ_RESTART = 1'b1;
      tick();
      if (GOJ1) g++;
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL b2b_seq got %b want %b", dut_vec(), mdl_vec()); end
    end
    n = 0;
    while (STATE === 3'd2 && n < 50) begin tick(); n++; if (GOJ1) g++; end
    n_checks++;
    if (g != 10 + GOJ_CYC) begin n_fail++; $display("FAIL b2b_goj_len got %0d want %0d", g, 10 + GOJ_CYC); end
  endtask

  task automatic test_watchdog();
    t12_run = 1'b0; T12 = 1'b0;
`ifdef TIMER_WDOG_EN
    begin
      int n;
      int a;
      n = 0;
      while (STATE === 3'd3 && n < 200) begin
        tick(); n++;
        n_checks++;
        if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL wdog_seq got %b want %b", dut_vec(), mdl_vec()); end
      end
      n_checks++;
      if ({STATE, ALGA, GOJ1} !== {3'd2, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL wdog_fire got %b want %b", {STATE, ALGA, GOJ1}, {3'd2, 1'b1, 1'b1});
      end
      a = 1; n = 0;
      while (STATE === 3'd2 && n < 50) begin tick(); n++; if (ALGA) a++; end
      n_checks++;
      if (a != GOJ_CYC) begin n_fail++; $display("FAIL wdog_alga_len got %0d want %0d", a, GOJ_CYC); end
    end
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      n_checks++;
      if ({STATE, ALGA} !== {3'd3, 1'b0} || dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL no_wdog got %b want %b", dut_vec(), mdl_vec());
      end
    end
`endif
    t12_run = 1'b1;
  endtask

  task automatic test_mid_reset();
    REQ_RESTART = 1'b1; tick();
    tick();
    SIM_RST_ = 1'b0; tick();
    n_checks++;
    if (dut_vec() !== 11'd0) begin n_fail++; $display("FAIL mid_reset got %b want %b", dut_vec(), 11'd0); end
    t12_run = 1'b0; T12 = 1'b0;
    tick();
    test_power_up();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        period  = $urandom_range(4, 30);
        t12_run = ($urandom_range(0, 3) != 0);
      end
      SIM_RST_    = ($urandom_range(0, 399) != 0);
      REQ_RESTART = ($urandom_range(0, 39) == 0);
      REQ_STBY    = ($urandom_range(0, 11) == 0);
      REQ_HALT    = ($urandom_range(0, 11) == 0);
      REQ_STEP    = ($urandom_range(0, 7) == 0);
      REQ_RUN     = ($urandom_range(0, 11) == 0);
      REQ_WAKE    = ($urandom_range(0, 11) == 0);
      tick();
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random cycle %0d got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    SIM_RST_ = 1'b1;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_halt_step();
    test_standby();
    test_priority();
    test_back_to_back();
    test_watchdog();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
